lock_key_conditioner: RTL and testbench

Input front-end for the FSM lock. It takes two raw, asynchronous, bouncy key buttons and produces clean single-cycle inp0/inp1 symbol pulses for the lock's sequence FSM. It rejects simultaneous or overlapping presses with a conflict pulse. It also emits a timeout pulse after a period of inactivity, so the system can reset a half-entered key.

---
 rtl/lock_key_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_lock_key_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_conditioner.sv
// lock_key_conditioner
// Input front-end for the sequence lock. Two raw, bouncy, asynchronous key
// buttons are synchronized, debounced and turned into clean one-cycle symbol
// pulses. Overlapping presses produce a conflict pulse instead of a symbol,
// and a timeout pulse fires after a period of inactivity following a symbol.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   btn0     in   raw key-0 button, active-high, asynchronous
//   btn1     in   raw key-1 button, active-high, asynchronous
//   inp0     out  one-cycle pulse: symbol 0 accepted
//   inp1     out  one-cycle pulse: symbol 1 accepted
//   conflict out  one-cycle pulse: both keys pressed together / overlapping
//   timeout  out  one-cycle pulse: inactivity timeout expired
//   busy     out  high while the key FSM is not in IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no key held; waiting for a press, timeout may be running
// HELD0 | key 0 accepted and still held
// HELD1 | key 1 accepted and still held
// JAM   | overlapping press seen; wait for both keys released

module lock_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    output logic inp0,
    output logic inp1,
    output logic conflict,
    output logic timeout,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD0 = 2'd1,
        HELD1 = 2'd2,
        JAM   = 2'd3
    } state_t;

    logic [1:0]          s1_q, s2_q;
    logic [1:0]          deb_q, deb_d;
    logic [1:0][DW-1:0]  cnt_q, cnt_d;
    state_t              state_q, state_d;
    logic                inp0_q, inp0_d, inp1_q, inp1_d;
    logic                conflict_q, conflict_d, timeout_q, timeout_d;
    logic                busy_q;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                armed_q, armed_d;

    // Debounce: the synchronized level must disagree with the debounced
    // level for DEBOUNCE_CYCLES consecutive clocks before it is adopted.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        inp0_d     = 1'b0;
        inp1_d     = 1'b0;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_q[0] && deb_q[1]) begin
                    state_d    = JAM;
                    conflict_d = 1'b1;
                end else if (deb_q[0]) begin
                    state_d = HELD0;
                    inp0_d  = 1'b1;
                end else if (deb_q[1]) begin
                    state_d = HELD1;
                    inp1_d  = 1'b1;
                end
            end
            HELD0: begin
                if (deb_q[1]) begin
                    state_d    = JAM;
                    conflict_d = 1'b1;
                end else if (!deb_q[0]) begin
                    state_d = IDLE;
                end
            end
            HELD1: begin
                if (deb_q[0]) begin
                    state_d    = JAM;
                    conflict_d = 1'b1;
                end else if (!deb_q[1]) begin
                    state_d = IDLE;
                end
            end
            JAM: begin
                if (!deb_q[0] && !deb_q[1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Inactivity timer. A symbol accepted on the expiry edge takes priority,
    // which also keeps timeout mutually exclusive with the other pulses.
    always_comb begin
        tcnt_d    = tcnt_q;
        armed_d   = armed_q;
        timeout_d = 1'b0;
        if (inp0_d || inp1_d) begin
            tcnt_d  = '0;
            armed_d = TO_EN;
        end else if (conflict_d) begin
            armed_d = 1'b0;
        end else if (armed_q && (state_q == IDLE)) begin
            if (tcnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                armed_d   = 1'b0;
                tcnt_d    = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            inp0_q     <= 1'b0;
            inp1_q     <= 1'b0;
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            tcnt_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            s1_q       <= {btn1, btn0};
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            inp0_q     <= inp0_d;
            inp1_q     <= inp1_d;
            conflict_q <= conflict_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != IDLE);
            tcnt_q     <= tcnt_d;
            armed_q    <= armed_d;
        end
    end

    assign inp0     = inp0_q;
    assign inp1     = inp1_q;
    assign conflict = conflict_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lock_key_conditioner.sv
module tb_lock_key_conditioner;

    localparam int DEB = 4;
    localparam int TO  = 10;

    localparam int K_INP0 = 0;
    localparam int K_INP1 = 1;
    localparam int K_CONF = 2;
    localparam int K_TOUT = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn0, btn1;
    logic inp0, inp1, conflict, timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    lock_key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn0    (btn0),
        .btn1    (btn1),
        .inp0    (inp0),
        .inp1    (inp1),
        .conflict(conflict),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;

    // Reference model: 2-sample delay line, a history window for debounce,
    // a key-mode variable and an idle-cycle tally for the timeout.
    bit  ms1[2], ms2[2], mdeb[2];
    bit  hist[2][DEB];
    int  hn[2];
    int  mode;
    bit  marmed;
    int  midle;
    bit  exp_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                ms1[b] = 0; ms2[b] = 0; mdeb[b] = 0; hn[b] = 0;
            end
            mode = 0; marmed = 0; midle = 0; exp_busy = 0;
            while (exp_q.size() > 0 && exp_q[$].cyc == cyc) void'(exp_q.pop_back());
        end else begin
            bit dp[2];
            bit btn[2];
            bit all_diff;
            int kind;
            int nm;
            cyc++;
            btn[0] = btn0;
            btn[1] = btn1;
            for (int b = 0; b < 2; b++) begin
                dp[b] = mdeb[b];
                for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = ms2[b];
                if (hn[b] < DEB) hn[b]++;
                all_diff = (hn[b] == DEB);
                for (int k = 0; k < DEB; k++) if (hist[b][k] == mdeb[b]) all_diff = 0;
                if (all_diff) mdeb[b] = !mdeb[b];
                ms2[b] = ms1[b];
                ms1[b] = btn[b];
            end
            kind = -1;
            nm   = mode;
            case (mode)
                0: if (dp[0] && dp[1]) begin nm = 3; kind = K_CONF; end
                   else if (dp[0]) begin nm = 1; kind = K_INP0; end
                   else if (dp[1]) begin nm = 2; kind = K_INP1; end
                1: if (dp[1]) begin nm = 3; kind = K_CONF; end
                   else if (!dp[0]) nm = 0;
                2: if (dp[0]) begin nm = 3; kind = K_CONF; end
                   else if (!dp[1]) nm = 0;
                default: if (!dp[0] && !dp[1]) nm = 0;
            endcase
            if (kind == K_INP0 || kind == K_INP1) begin
                marmed = 1; midle = 0;
            end else if (kind == K_CONF) begin
                marmed = 0;
            end else if (marmed && mode == 0) begin
                midle++;
                if (midle == TO) begin
                    kind = K_TOUT; marmed = 0; midle = 0;
                end
            end
            mode = nm;
            exp_busy = (nm != 0);
            if (kind >= 0) exp_q.push_back('{kind: kind, cyc: cyc});
        end
    end

    // Monitor: sample on the falling edge, pop the scoreboard on any pulse.
    always @(negedge clk) begin
        int npulse;
        int k;
        if (!rst) begin
            n_cmp++;
            if ({inp0, inp1, conflict, timeout, busy} != 5'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc,
                         {inp0, inp1, conflict, timeout, busy});
            end
        end else begin
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            npulse = int'(inp0) + int'(inp1) + int'(conflict) + int'(timeout);
            k = inp0 ? K_INP0 : inp1 ? K_INP1 : conflict ? K_CONF : K_TOUT;
            if (npulse > 1) begin
                n_cmp++; n_bad++;
                $display("FAIL onehot cyc=%0d got=%b want=at most one", cyc,
                         {inp0, inp1, conflict, timeout});
            end
            if (npulse >= 1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse cyc=%0d got kind=%0d want none", cyc, k);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                ev_t e;
                e = exp_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_pulse cyc=%0d got none want kind=%0d cyc=%0d",
                         cyc, e.kind, e.cyc);
            end
        end
    end

    task automatic drive(input bit b0, input bit b1, input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            btn0 = b0;
            btn1 = b1;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (n) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; btn0 = 1'b0; btn1 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        drive(0, 0, 5);

        // clean press of key 0
        drive(1, 0, 20);
        drive(0, 0, 25);
        // bouncing key 1, then steady
        drive(0, 1, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
        drive(0, 1, 15);
        drive(0, 0, 25);
        // simultaneous press
        drive(1, 1, 15);
        drive(0, 0, 25);
        // overlap: key 0 then key 1, release key 1 only, then both
        drive(1, 0, 15);
        drive(1, 1, 15);
        drive(1, 0, 15);
        drive(0, 0, 25);
        // timeout vs. a new symbol landing around the expiry edge
        for (int gap = 8; gap <= 12; gap++) begin
            drive(0, 1, 12);
            drive(0, 0, gap);
            drive(1, 0, 12);
            drive(0, 0, 30);
        end
        // reset mid-debounce with key 0 held
        drive(1, 0, 3);
        do_reset(3);
        drive(1, 0, 15);
        drive(0, 0, 25);
        // reset while a pulse is about to issue
        drive(0, 1, 6);
        do_reset(2);
        drive(0, 0, 20);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 12));
            end
        end
        drive(0, 0, 40);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
